// File: rtl/pio_pkg.sv
// Shared register map and edge-mode encodings for the parallel I/O port.
package pio_pkg;

    typedef enum logic [1:0] {
        REG_DATA = 2'd0,
        REG_OUT  = 2'd1,
        REG_EDGE = 2'd2,
        REG_MASK = 2'd3
    } pio_reg_e;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_BOTH = 2;

    // True when a debounced bit moved in the direction selected by mode.
    function automatic logic edge_hit(input int unsigned mode, input logic cur, input logic prev);
        case (mode)
            EDGE_RISE: return cur & ~prev;
            EDGE_FALL: return ~cur & prev;
            default:   return cur ^ prev;
        endcase
    endfunction

endpackage

// File: rtl/pio_debounce.sv
// One pin: synchronizer chain, then a sample register that only commits to the
// debounced output after two consecutive tick samples agree.
module pio_debounce #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_pin,
    output logic o_deb
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sample;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample <= 1'b0;
            o_deb    <= 1'b0;
        end else if (i_tick) begin
            r_sample <= w_sync;
            if (w_sync == r_sample) begin
                o_deb <= w_sync;
            end
        end
    end

endmodule

// File: rtl/parallel_io_port.sv
// Memory-mapped parallel I/O port: debounced inputs with edge capture and a
// masked interrupt, plus a latched output register.
module parallel_io_port
    import pio_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned PIO_W       = 10,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 50000,
    parameter int unsigned EDGE_MODE   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        ADDR,
    input  logic              W,
    input  logic [DATA_W-1:0] DOUT,
    output logic [DATA_W-1:0] DIN,
    input  logic [PIO_W-1:0]  pin_in,
    output logic [PIO_W-1:0]  pin_out,
    output logic              irq
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [CNT_W-1:0] r_tick_cnt;
    logic             w_tick;
    logic [PIO_W-1:0] w_deb;
    logic [PIO_W-1:0] r_deb_prev;
    logic [PIO_W-1:0] w_edge_new;
    logic [PIO_W-1:0] w_edge_clr;
    logic [PIO_W-1:0] r_edge;
    logic [PIO_W-1:0] r_mask;
    logic [PIO_W-1:0] w_rd;
    logic             w_wr_out;
    logic             w_wr_edge;
    logic             w_wr_mask;
    logic             w_unused_dout;

    // Only the low PIO_W bits of the write bus carry meaning.
    assign w_unused_dout = ^DOUT;

    // Free-running debounce sample timer shared by every pin.
    assign w_tick = (r_tick_cnt == CNT_W'(DEB_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < int'(PIO_W); g++) begin : g_deb
        pio_debounce #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_deb (
            .clk    (clk),
            .rst    (rst),
            .i_tick (w_tick),
            .i_pin  (pin_in[g]),
            .o_deb  (w_deb[g])
        );
    end

    assign w_wr_out  = W && (ADDR == REG_OUT);
    assign w_wr_edge = W && (ADDR == REG_EDGE);
    assign w_wr_mask = W && (ADDR == REG_MASK);
    assign w_edge_clr = w_wr_edge ? DOUT[PIO_W-1:0] : '0;

    always_comb begin
        w_edge_new = '0;
        for (int i = 0; i < int'(PIO_W); i++) begin
            w_edge_new[i] = edge_hit(EDGE_MODE, w_deb[i], r_deb_prev[i]);
        end
    end

    always_comb begin
        w_rd = '0;
        case (ADDR)
            REG_DATA: w_rd = w_deb;
            REG_OUT:  w_rd = pin_out;
            REG_EDGE: w_rd = r_edge;
            REG_MASK: w_rd = r_mask;
            default:  w_rd = '0;
        endcase
    end

    // A fresh edge overrides a simultaneous write-1-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb_prev <= '0;
            r_edge     <= '0;
            r_mask     <= '0;
            pin_out    <= '0;
            irq        <= 1'b0;
            DIN        <= '0;
        end else begin
            r_deb_prev <= w_deb;
            r_edge     <= (r_edge & ~w_edge_clr) | w_edge_new;
            if (w_wr_mask) begin
                r_mask <= DOUT[PIO_W-1:0];
            end
            if (w_wr_out) begin
                pin_out <= DOUT[PIO_W-1:0];
            end
            irq <= |(r_edge & r_mask);
            DIN <= DATA_W'(w_rd);
        end
    end

endmodule

// File: tb/tb_parallel_io_port.sv
// Scoreboard bench for parallel_io_port: stimulus queues expected values, a
// negedge monitor pops and compares when the registered outputs are presented.
module tb_parallel_io_port;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned PIO_W  = 10;
    localparam int K_DIN = 0;
    localparam int K_PIN = 1;
    localparam int K_IRQ = 2;

    typedef struct {
        int          kind;
        logic [15:0] exp;
        string       name;
    } chk_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        ADDR = 2'd0;
    logic              W = 1'b0;
    logic [DATA_W-1:0] DOUT = '0;
    logic [DATA_W-1:0] DIN;
    logic [PIO_W-1:0]  pin_in = '0;
    logic [PIO_W-1:0]  pin_out;
    logic              irq;

    chk_t        sb_q[$];
    chk_t        mon_e;
    logic [15:0] mon_act;
    int          req_cnt = 0;
    int          vld_cnt = 0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          drain = 1'b0;
    int          cyc;

    always #5 clk = ~clk;

    parallel_io_port #(
        .DATA_W(DATA_W), .PIO_W(PIO_W), .SYNC_STAGES(2), .DEB_CYCLES(4), .EDGE_MODE(0)
    ) dut (
        .clk(clk), .rst(rst), .ADDR(ADDR), .W(W), .DOUT(DOUT), .DIN(DIN),
        .pin_in(pin_in), .pin_out(pin_out), .irq(irq)
    );

    // Outputs requested in one cycle are presented after the following edge.
    always @(posedge clk) vld_cnt <= req_cnt;

    // Mirrors the debounce timer phase: counts clock edges since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        for (int i = 0; i < vld_cnt; i++) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL monitor_underrun: actual no pending entry, required one");
            end else begin
                mon_e = sb_q.pop_front();
                case (mon_e.kind)
                    K_DIN:   mon_act = DIN;
                    K_PIN:   mon_act = 16'(pin_out);
                    default: mon_act = {15'd0, irq};
                endcase
                if (mon_act !== mon_e.exp) begin
                    miscompares++;
                    $display("FAIL %s: actual 0x%04h required 0x%04h", mon_e.name, mon_act, mon_e.exp);
                end
            end
        end
        if (drain) begin
            vectors++;
            if (sb_q.size() != 0) begin
                miscompares++;
                $display("FAIL scoreboard_drain: actual %0d pending, required 0", sb_q.size());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        W = 1'b0;
        req_cnt = 0;
        @(negedge clk);
    endtask

    task automatic chk(input int kind, input logic [1:0] addr, input logic [15:0] exp, input string name);
        chk_t e;
        if (kind == K_DIN) ADDR = addr;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
        req_cnt++;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        ADDR = a;
        DOUT = d;
        W    = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk(K_DIN, 2'd3, 16'h0000, "reset_mask_read");
        chk(K_PIN, 2'd0, 16'h0000, "reset_pin_out");
        chk(K_IRQ, 2'd0, 16'h0000, "reset_irq");
        step();
        chk(K_DIN, 2'd2, 16'h0000, "reset_edge_read");
        step();

        // Stable level on bit 9 debounces and captures a rising edge.
        pin_in = 10'b10_0000_0000;
        repeat (11) step();
        chk(K_DIN, 2'd0, 16'h0200, "deb_bit9");
        step();
        chk(K_DIN, 2'd2, 16'h0200, "edge_bit9");
        chk(K_IRQ, 2'd0, 16'h0000, "irq_unmasked");
        step();
        step();

        // Two-cycle glitch on bit 0 must be filtered out.
        pin_in[0] = 1'b1;
        step();
        step();
        pin_in[0] = 1'b0;
        repeat (12) step();
        chk(K_DIN, 2'd0, 16'h0200, "glitch_data");
        step();
        chk(K_DIN, 2'd2, 16'h0200, "glitch_edge");
        step();

        // Mask then clear: irq follows one cycle behind each update.
        wr(2'd3, 16'h0200);
        chk(K_IRQ, 2'd0, 16'h0000, "irq_mask_latency");
        step();
        chk(K_IRQ, 2'd0, 16'h0001, "irq_set");
        chk(K_DIN, 2'd3, 16'h0200, "mask_readback");
        step();
        wr(2'd2, 16'h0200);
        chk(K_IRQ, 2'd0, 16'h0001, "irq_clear_latency");
        step();
        chk(K_IRQ, 2'd0, 16'h0000, "irq_cleared");
        chk(K_DIN, 2'd2, 16'h0000, "edge_cleared");
        step();

        // Output register loads; DATA writes are ignored.
        wr(2'd1, 16'h0155);
        chk(K_PIN, 2'd0, 16'h0155, "out_load");
        step();
        wr(2'd0, 16'h03FF);
        chk(K_PIN, 2'd0, 16'h0155, "data_write_ignored");
        step();
        chk(K_PIN, 2'd0, 16'h0155, "data_write_ignored2");
        chk(K_DIN, 2'd1, 16'h0155, "out_readback");
        step();

        // Align to the debounce tick so the clear lands on bit 1's edge cycle.
        for (int n = 0; n < 8 && (cyc % 4) != 0; n++) step();
        pin_in[1] = 1'b1;
        repeat (8) step();
        wr(2'd2, 16'h0002);
        chk(K_DIN, 2'd2, 16'h0000, "edge_before_race");
        step();
        chk(K_DIN, 2'd2, 16'h0002, "edge_set_wins_clear");
        step();
        chk(K_DIN, 2'd0, 16'h0202, "deb_bit1");
        step();
        step();

        @(posedge clk);
        #1 drain = 1'b1;
        @(posedge clk);
        #1 drain = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/parallel_io_port.md
PARALLEL_IO_PORT -- requirements
Module: parallel_io_port

Interface
REQ-001 Parameter DATA_W, default 16: processor bus data width.
REQ-002 Parameter PIO_W, default 10: number of input pins and number of output pins (PIO_W <= DATA_W).
REQ-003 Parameter SYNC_STAGES, default 2: input synchronizer depth (>= 2).
REQ-004 Parameter DEB_CYCLES, default 50000: debounce sample period in clocks (>= 2).
REQ-005 Parameter EDGE_MODE, default 0: edge capture mode (0 rising, 1 falling, 2 both).
REQ-006 Clock  in  1  single system clock; all state on rising edge.
REQ-007 Reset  in  1  asynchronous, active-high reset.
REQ-008 ADDR  in  2  register select (0 DATA, 1 OUT, 2 EDGE, 3 MASK).
REQ-009 W  in  1  write strobe, one cycle per write.
REQ-010 DOUT  in  DATA_W  write data from processor.
REQ-011 DIN  out  DATA_W  registered read data, zero-extended from PIO_W.
REQ-012 pin_in  in  PIO_W  asynchronous external inputs (switches).
REQ-013 pin_out  out  PIO_W  registered outputs (LEDs).
REQ-014 irq  out  1  registered interrupt request.

Function
REQ-015 Each pin_in bit SHALL pass through a SYNC_STAGES flip-flop chain before any other use.
REQ-016 A shared tick counter SHALL count 0..DEB_CYCLES-1 and wrap; tick asserts for the one cycle the count equals DEB_CYCLES-1.
REQ-017 On tick, each bit SHALL store its synchronized value as sample; debounced bit SHALL take the new sample only when it equals the previous sample.
REQ-018 A pin change stable for 2*DEB_CYCLES cycles SHALL appear on the debounced value within SYNC_STAGES+2*DEB_CYCLES+1 cycles; a glitch shorter than DEB_CYCLES SHALL never appear.
REQ-019 An edge bit SHALL set on the clock edge after its debounced bit changes in the direction selected by EDGE_MODE, and stay set until cleared.
REQ-020 Write to EDGE SHALL clear each bit where DOUT is 1 (write-1-to-clear); a new edge in the same cycle SHALL win and leave the bit set.
REQ-021 Write to OUT SHALL load pin_out with DOUT[PIO_W-1:0] at the next edge; write to DATA SHALL be ignored.
REQ-022 Write to MASK SHALL load the PIO_W-bit interrupt mask.
REQ-023 DIN SHALL present, one cycle after ADDR is sampled, the debounced value (0), pin_out (1), edge register (2) or mask (3); upper DATA_W-PIO_W bits zero.
REQ-024 Reads SHALL have no side effects.
REQ-025 irq SHALL equal the OR of (edge AND mask) registered, i.e. one cycle after the edge or mask update.
REQ-026 Tick counter SHALL run continuously, independent of bus activity.

Reset
REQ-027 Reset SHALL asynchronously clear synchronizers, samples, debounced value, edge, mask, pin_out, tick counter, DIN and irq to 0.
REQ-028 A pin held high across reset release SHALL be treated as a 0->1 change and captured as a rising edge.
REQ-029 Reset asserted mid-debounce or mid-write SHALL discard the pending update; no partial state survives.

Structure
REQ-030 Register address constants and EDGE_MODE encodings SHALL live in shared package pio_pkg.
REQ-031 Per-bit synchronizer plus sample/debounce logic SHALL be one sub-module, pio_debounce, instantiated PIO_W times via generate, sharing the tick.
REQ-032 Register file, edge detection, read mux and irq SHALL reside in parallel_io_port.

Verification (bench: DEB_CYCLES=4, PIO_W=10, SYNC_STAGES=2, EDGE_MODE=0)
REQ-033 Reset high 2 cycles, release -> DIN, pin_out, irq all 0; ADDR=3 reads 0x0000.
REQ-034 pin_in=10'b1000000000 held 20 cycles, ADDR=0 -> DIN=0x0200 within 11 cycles; ADDR=2 -> 0x0200.
REQ-035 pin_in bit 0 pulsed high 2 cycles -> debounced value and edge register unchanged.
REQ-036 MASK=0x0200 with edge bit 9 set -> irq=1 one cycle later; write EDGE=0x0200 -> irq=0 one cycle after clear.
REQ-037 Write OUT=0x0155 -> pin_out=10'b0101010101 next cycle; write DATA=0x03FF -> pin_out unchanged.
REQ-038 EDGE clear issued the same cycle bit 1 debounces 0->1 -> edge bit 1 remains 1.
